fixed_shift_divider: RTL and testbench

FIXED_SHIFT_DIVIDER -- requirements
Module: fixed_shift_divider

---
 rtl/fixed_shift_divider.sv | 241 ++++++++++++++++++++++++
 tb/tb_fixed_shift_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_shift_divider.sv
// Streams q = (x * mult_inv) >> BITS_EXPONENT as NUM_BLOCKS_OUT blocks, LSB block first.
// Optional high-bit overflow detection is enabled by defining FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN.
module fixed_shift_divider #(
    parameter int unsigned REGISTER_SIZE  = 32,
    parameter int unsigned NUM_BLOCKS_IN  = 128,
    parameter int unsigned BITS_EXPONENT  = 6080,
    parameter int unsigned NUM_BLOCKS_OUT = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic [REGISTER_SIZE-1:0] x_block_in,
    input  logic [REGISTER_SIZE-1:0] mult_inv_constant_block_in,
    output logic                     ready_out,
    output logic                     valid_out,
    output logic [REGISTER_SIZE-1:0] data_block_out,
    output logic                     done_out,
    output logic                     overflow_out
);
    localparam int unsigned B    = BITS_EXPONENT / REGISTER_SIZE;
    localparam int unsigned S    = BITS_EXPONENT % REGISTER_SIZE;
    localparam int unsigned IN_W = $clog2(NUM_BLOCKS_IN) + 1;
    localparam int unsigned PC_W = $clog2(2 * NUM_BLOCKS_IN) + 1;
    localparam logic [PC_W-1:0] FIRST_OUT_BEAT = PC_W'(B + 1);
    localparam logic [PC_W-1:0] LAST_OUT_BEAT  = PC_W'(B + NUM_BLOCKS_OUT);
    localparam logic [PC_W-1:0] LAST_BEAT      = PC_W'(2 * NUM_BLOCKS_IN - 1);

    if (B + NUM_BLOCKS_OUT >= 2 * NUM_BLOCKS_IN) begin : g_param_check
        $error("fixed_shift_divider: BITS_EXPONENT/REGISTER_SIZE + NUM_BLOCKS_OUT must be < 2*NUM_BLOCKS_IN");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FLUSH} state_t;

    state_t                   state;
    logic [IN_W-1:0]          in_cnt;
    logic [PC_W-1:0]          prod_cnt;
    logic [REGISTER_SIZE-1:0] prev_block;
    logic                     accept;
    logic                     mult_clear;
    logic                     prod_valid;
    logic [REGISTER_SIZE-1:0] prod_block;
    logic [REGISTER_SIZE-1:0] window;

    assign accept     = valid_in && ready_out;
    assign mult_clear = (state == FLUSH);
    // Output block straddles two adjacent product blocks when the shift is not block aligned
    assign window     = REGISTER_SIZE'({prod_block, prev_block} >> S);

    fsm_multiplier #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .BITS_IN_NUM   (REGISTER_SIZE * NUM_BLOCKS_IN)
    ) u_mult (
        .clk           (clk_in),
        .rst           (rst_in),
        .clear         (mult_clear),
        .valid_in      (accept),
        .a_block       (x_block_in),
        .b_block       (mult_inv_constant_block_in),
        .valid_out     (prod_valid),
        .product_block (prod_block)
    );

`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
    localparam int unsigned TOP_BIT = BITS_EXPONENT + REGISTER_SIZE * NUM_BLOCKS_OUT;
    localparam logic [PC_W-1:0] OVF_BEAT = PC_W'(TOP_BIT / REGISTER_SIZE);
    localparam logic [REGISTER_SIZE-1:0] OVF_MASK =
        ~((REGISTER_SIZE'(1) << (TOP_BIT % REGISTER_SIZE)) - REGISTER_SIZE'(1));

    logic ovf_acc;
    logic beat_ovf;

    // Any set product bit at or above TOP_BIT means the quotient did not fit
    always_comb begin
        beat_ovf = 1'b0;
        if (prod_cnt > OVF_BEAT) begin
            beat_ovf = |prod_block;
        end else if (prod_cnt == OVF_BEAT) begin
            beat_ovf = |(prod_block & OVF_MASK);
        end
    end
`else
    assign overflow_out = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            in_cnt         <= '0;
            prod_cnt       <= '0;
            prev_block     <= '0;
            ready_out      <= 1'b0;
            valid_out      <= 1'b0;
            data_block_out <= '0;
            done_out       <= 1'b0;
`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
            ovf_acc        <= 1'b0;
            overflow_out   <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            done_out  <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    ready_out <= 1'b1;
                    if (accept) begin
`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
                        if (state == IDLE) begin
                            ovf_acc      <= 1'b0;
                            overflow_out <= 1'b0;
                        end
`endif
                        if (in_cnt == IN_W'(NUM_BLOCKS_IN - 1)) begin
                            in_cnt    <= '0;
                            state     <= DRAIN;
                            ready_out <= 1'b0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (prod_valid) begin
                        prev_block <= prod_block;
                        prod_cnt   <= prod_cnt + 1'b1;
                        if (prod_cnt >= FIRST_OUT_BEAT && prod_cnt <= LAST_OUT_BEAT) begin
                            valid_out      <= 1'b1;
                            data_block_out <= window;
                        end
`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
                        ovf_acc <= ovf_acc | beat_ovf;
`endif
                        if (prod_cnt == LAST_BEAT) begin
                            prod_cnt <= '0;
                            state    <= FLUSH;
                            done_out <= 1'b1;
`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
                            overflow_out <= ovf_acc | beat_ovf;
`endif
                        end
                    end
                end
                FLUSH: begin
                    state     <= IDLE;
                    ready_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// Schoolbook multiplier: loads operand blocks, then emits one product column per cycle, LSB first.
module fsm_multiplier #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_NUM   = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid_in,
    input  logic [REGISTER_SIZE-1:0] a_block,
    input  logic [REGISTER_SIZE-1:0] b_block,
    output logic                     valid_out,
    output logic [REGISTER_SIZE-1:0] product_block
);
    localparam int unsigned NB      = BITS_IN_NUM / REGISTER_SIZE;
    localparam int unsigned IDX_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned COL_W   = $clog2(2 * NB) + 1;
    localparam int unsigned ACC_W   = 2 * REGISTER_SIZE + $clog2(NB) + 1;
    localparam int unsigned CARRY_W = ACC_W - REGISTER_SIZE;

    typedef enum logic [1:0] {M_LOAD, M_RUN, M_DONE} mstate_t;

    mstate_t                  state;
    logic [REGISTER_SIZE-1:0] a_mem [NB];
    logic [REGISTER_SIZE-1:0] b_mem [NB];
    logic [IDX_W-1:0]         load_cnt;
    logic [COL_W-1:0]         col;
    logic [CARRY_W-1:0]       carry;
    logic [ACC_W-1:0]         acc;
    int                       b_idx;

    // Column sum: carry-in plus every partial product a[i]*b[col-i]
    always_comb begin
        acc   = ACC_W'(carry);
        b_idx = 0;
        for (int i = 0; i < int'(NB); i++) begin
            b_idx = int'(col) - i;
            if (b_idx >= 0 && b_idx < int'(NB)) begin
                acc = acc + ACC_W'(a_mem[IDX_W'(i)]) * ACC_W'(b_mem[IDX_W'(b_idx)]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= M_LOAD;
            load_cnt      <= '0;
            col           <= '0;
            carry         <= '0;
            valid_out     <= 1'b0;
            product_block <= '0;
        end else if (clear) begin
            state         <= M_LOAD;
            load_cnt      <= '0;
            col           <= '0;
            carry         <= '0;
            valid_out     <= 1'b0;
            product_block <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                M_LOAD: begin
                    if (valid_in) begin
                        a_mem[load_cnt] <= a_block;
                        b_mem[load_cnt] <= b_block;
                        if (load_cnt == IDX_W'(NB - 1)) begin
                            load_cnt <= '0;
                            state    <= M_RUN;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                M_RUN: begin
                    product_block <= acc[REGISTER_SIZE-1:0];
                    valid_out     <= 1'b1;
                    carry         <= CARRY_W'(acc >> REGISTER_SIZE);
                    if (col == COL_W'(2 * NB - 1)) begin
                        col   <= '0;
                        state <= M_DONE;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ; // M_DONE: idle until the owner clears us
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_shift_divider.sv
// Directed bench for fixed_shift_divider: two instances (shift 12 and shift 16) share one stimulus stream.
module tb_fixed_shift_divider;
    localparam int unsigned RS  = 8;
    localparam int unsigned NBI = 4;
    localparam int unsigned NBO = 2;
`ifdef FIXED_SHIFT_DIVIDER_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [RS-1:0] x_block = '0;
    logic [RS-1:0] inv_block = '0;

    logic          ready_a, valid_a, done_a, ovf_a;
    logic [RS-1:0] data_a;
    logic          ready_b, valid_b, done_b, ovf_b;
    logic [RS-1:0] data_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [RS-1:0] qa[$];
    logic [RS-1:0] qb[$];
    int   dn_a = 0;
    int   dn_b = 0;
    logic od_a = 1'b0;
    logic od_b = 1'b0;

    fixed_shift_divider #(
        .REGISTER_SIZE(RS), .NUM_BLOCKS_IN(NBI), .BITS_EXPONENT(12), .NUM_BLOCKS_OUT(NBO)
    ) dut_a (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .x_block_in(x_block),
        .mult_inv_constant_block_in(inv_block), .ready_out(ready_a), .valid_out(valid_a),
        .data_block_out(data_a), .done_out(done_a), .overflow_out(ovf_a)
    );

    fixed_shift_divider #(
        .REGISTER_SIZE(RS), .NUM_BLOCKS_IN(NBI), .BITS_EXPONENT(16), .NUM_BLOCKS_OUT(NBO)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .x_block_in(x_block),
        .mult_inv_constant_block_in(inv_block), .ready_out(ready_b), .valid_out(valid_b),
        .data_block_out(data_b), .done_out(done_b), .overflow_out(ovf_b)
    );

    always #5 clk = ~clk;

    // Capture every emitted quotient block and the overflow flag seen with each done pulse
    always @(negedge clk) begin
        if (valid_a) qa.push_back(data_a);
        if (valid_b) qb.push_back(data_b);
        if (done_a) begin dn_a++; od_a = ovf_a; end
        if (done_b) begin dn_b++; od_b = ovf_b; end
    end

    function automatic logic [RS-1:0] get_a(input int i);
        if (i < qa.size()) return qa[i];
        return 'x;
    endfunction

    function automatic logic [RS-1:0] get_b(input int i);
        if (i < qb.size()) return qb[i];
        return 'x;
    endfunction

    task automatic drive_job(input logic [31:0] x, input logic [31:0] inv, input bit gap, output bit ok);
        int beat = 0;
        int cyc  = 0;
        bit skip = 1'b0;
        while (beat < int'(NBI) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gap && skip) begin
                valid_in = 1'b0;
            end else if (ready_a) begin
                valid_in  = 1'b1;
                x_block   = x[beat*RS +: RS];
                inv_block = inv[beat*RS +: RS];
                beat++;
            end else begin
                valid_in = 1'b0;
            end
            skip = !skip;
        end
        @(negedge clk);
        valid_in = 1'b0;
        ok = (beat == int'(NBI));
    endtask

    task automatic wait_done(input int target, output bit ok);
        int cyc = 0;
        while (dn_a < target && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ok = (dn_a >= target);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready_a); end
        n_vec++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_a); end
        n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done_a); end
        n_vec++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_a); end
        n_vec++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", ovf_a); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", ready_a); end
    endtask

    task automatic test_shift_paths();
        int ba = qa.size();
        int bb = qb.size();
        int da = dn_a;
        int db = dn_b;
        bit ok1, ok2;
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b0, ok1);
        wait_done(da + 1, ok2);
        n_vec++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL shift_timeout got load=%0d done=%0d want 1 1", ok1, ok2); end
        n_vec++; if (qa.size() - ba != int'(NBO)) begin n_bad++; $display("FAIL shift12_count got %0d want 2", qa.size() - ba); end
        n_vec++; if (get_a(ba) !== 8'hCD) begin n_bad++; $display("FAIL shift12_blk0 got %h want cd", get_a(ba)); end
        n_vec++; if (get_a(ba + 1) !== 8'hAB) begin n_bad++; $display("FAIL shift12_blk1 got %h want ab", get_a(ba + 1)); end
        n_vec++; if (get_b(bb) !== 8'hBC) begin n_bad++; $display("FAIL shift16_blk0 got %h want bc", get_b(bb)); end
        n_vec++; if (get_b(bb + 1) !== 8'h0A) begin n_bad++; $display("FAIL shift16_blk1 got %h want 0a", get_b(bb + 1)); end
        n_vec++; if (dn_a - da != 1) begin n_bad++; $display("FAIL shift12_done_pulses got %0d want 1", dn_a - da); end
        n_vec++; if (dn_b - db != 1) begin n_bad++; $display("FAIL shift16_done_pulses got %0d want 1", dn_b - db); end
        n_vec++; if (od_a !== 1'b0) begin n_bad++; $display("FAIL shift12_overflow got %b want 0", od_a); end
        n_vec++; if (od_b !== 1'b0) begin n_bad++; $display("FAIL shift16_overflow got %b want 0", od_b); end
    endtask

    task automatic test_overflow();
        int ba = qa.size();
        int bb = qb.size();
        int da = dn_a;
        bit ok1, ok2;
        drive_job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, ok1);
        wait_done(da + 1, ok2);
        n_vec++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL ovf_timeout got load=%0d done=%0d want 1 1", ok1, ok2); end
        n_vec++; if (qa.size() - ba != int'(NBO)) begin n_bad++; $display("FAIL ovf_count got %0d want 2", qa.size() - ba); end
        n_vec++; if (get_a(ba) !== 8'h00) begin n_bad++; $display("FAIL ovf12_blk0 got %h want 00", get_a(ba)); end
        n_vec++; if (get_a(ba + 1) !== 8'h00) begin n_bad++; $display("FAIL ovf12_blk1 got %h want 00", get_a(ba + 1)); end
        n_vec++; if (get_b(bb) !== 8'h00) begin n_bad++; $display("FAIL ovf16_blk0 got %h want 00", get_b(bb)); end
        n_vec++; if (get_b(bb + 1) !== 8'h00) begin n_bad++; $display("FAIL ovf16_blk1 got %h want 00", get_b(bb + 1)); end
        n_vec++; if (od_a !== OVF_EXP) begin n_bad++; $display("FAIL ovf12_at_done got %b want %b", od_a, OVF_EXP); end
        n_vec++; if (od_b !== OVF_EXP) begin n_bad++; $display("FAIL ovf16_at_done got %b want %b", od_b, OVF_EXP); end
        n_vec++; if (ovf_a !== OVF_EXP) begin n_bad++; $display("FAIL ovf12_held got %b want %b", ovf_a, OVF_EXP); end
    endtask

    task automatic test_gapped_drain();
        int ba = qa.size();
        int da = dn_a;
        int ready_seen = 0;
        bit ok1, ok2;
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b1, ok1);
        n_vec++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL gap_overflow_cleared got %b want 0", ovf_a); end
        for (int i = 0; i < 5; i++) begin
            valid_in  = 1'b1;
            x_block   = RS'($urandom);
            inv_block = RS'($urandom);
            @(negedge clk);
            if (ready_a) ready_seen++;
        end
        valid_in = 1'b0;
        n_vec++; if (ready_seen != 0) begin n_bad++; $display("FAIL gap_drain_ready got %0d high cycles want 0", ready_seen); end
        wait_done(da + 1, ok2);
        n_vec++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL gap_timeout got load=%0d done=%0d want 1 1", ok1, ok2); end
        n_vec++; if (qa.size() - ba != int'(NBO)) begin n_bad++; $display("FAIL gap_count got %0d want 2", qa.size() - ba); end
        n_vec++; if (get_a(ba) !== 8'hCD) begin n_bad++; $display("FAIL gap_blk0 got %h want cd", get_a(ba)); end
        n_vec++; if (get_a(ba + 1) !== 8'hAB) begin n_bad++; $display("FAIL gap_blk1 got %h want ab", get_a(ba + 1)); end
        n_vec++; if (dn_a - da != 1) begin n_bad++; $display("FAIL gap_done_pulses got %0d want 1", dn_a - da); end
    endtask

    task automatic test_reset_mid_drain();
        int ba;
        int da;
        bit ok1, ok2;
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b0, ok1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ba = qa.size();
        da = dn_a;
        n_vec++; if (valid_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL abort_outputs got valid=%b done=%b want 0 0", valid_a, done_a); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL abort_release_ready got %b want 1", ready_a); end
        repeat (30) @(negedge clk);
        n_vec++; if (qa.size() != ba) begin n_bad++; $display("FAIL abort_stray_blocks got %0d want 0", qa.size() - ba); end
        n_vec++; if (dn_a != da) begin n_bad++; $display("FAIL abort_stray_done got %0d want 0", dn_a - da); end
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b0, ok1);
        wait_done(da + 1, ok2);
        n_vec++; if (!ok2) begin n_bad++; $display("FAIL after_abort_timeout got %0d want 1", ok2); end
        n_vec++; if (qa.size() - ba != int'(NBO)) begin n_bad++; $display("FAIL after_abort_count got %0d want 2", qa.size() - ba); end
        n_vec++; if (get_a(ba) !== 8'hCD) begin n_bad++; $display("FAIL after_abort_blk0 got %h want cd", get_a(ba)); end
        n_vec++; if (get_a(ba + 1) !== 8'hAB) begin n_bad++; $display("FAIL after_abort_blk1 got %h want ab", get_a(ba + 1)); end
    endtask

    task automatic test_back_to_back();
        int ba = qa.size();
        int bb = qb.size();
        int da = dn_a;
        int db = dn_b;
        bit ok1, ok2, ok3;
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b0, ok1);
        drive_job(32'h00ABCDEF, 32'h00000010, 1'b0, ok2);
        wait_done(da + 2, ok3);
        n_vec++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL b2b_timeout got %0d%0d%0d want 111", ok1, ok2, ok3); end
        n_vec++; if (qa.size() - ba != 2 * int'(NBO)) begin n_bad++; $display("FAIL b2b_count got %0d want 4", qa.size() - ba); end
        n_vec++; if (get_a(ba) !== 8'hCD || get_a(ba + 1) !== 8'hAB) begin
            n_bad++; $display("FAIL b2b_job0 got %h %h want cd ab", get_a(ba), get_a(ba + 1)); end
        n_vec++; if (get_a(ba + 2) !== 8'hCD || get_a(ba + 3) !== 8'hAB) begin
            n_bad++; $display("FAIL b2b_job1 got %h %h want cd ab", get_a(ba + 2), get_a(ba + 3)); end
        n_vec++; if (get_b(bb + 2) !== 8'hBC || get_b(bb + 3) !== 8'h0A) begin
            n_bad++; $display("FAIL b2b_shift16_job1 got %h %h want bc 0a", get_b(bb + 2), get_b(bb + 3)); end
        n_vec++; if (dn_a - da != 2) begin n_bad++; $display("FAIL b2b_done_pulses got %0d want 2", dn_a - da); end
        n_vec++; if (dn_b - db != 2) begin n_bad++; $display("FAIL b2b_shift16_done_pulses got %0d want 2", dn_b - db); end
    endtask

    initial begin
        test_reset();
        test_shift_paths();
        test_overflow();
        test_gapped_drain();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
